// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Arbitrates the single register-file write port between the core
//   writeback path (requester 0) and the debug/load unit (requester 1).
//   Writeback normally wins. A starvation counter forces a debug grant
//   after STARVE_LIMIT consecutive denied debug cycles, and dbg_halt hands
//   the port to debug entirely. The accepted write is registered and shows
//   up on WE3/A3/WD3/grant_id one cycle after the handshake.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active low
//   wb_valid   writeback request          wb_addr/wb_data   its payload
//   wb_ready   writeback accepted this cycle (combinational)
//   dbg_valid  debug request              dbg_addr/dbg_data its payload
//   dbg_ready  debug accepted this cycle (combinational)
//   dbg_halt   debug owns the port, writeback blocked from next cycle
//   WE3        register-file write enable (registered, one-cycle pulse)
//   A3, WD3    register-file write address / data (registered)
//   grant_id   requester behind the current A3/WD3 (0 = wb, 1 = dbg)
module regfile_wr_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            dbg_valid,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  output logic            dbg_ready,
  input  logic            dbg_halt,
  output logic            WE3,
  output logic [4:0]      A3,
  output logic [XLEN-1:0] WD3,
  output logic            grant_id
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FORCE  = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [2:0]      cnt_nxt;
  logic            wb_xfer_p0;
  logic            dbg_xfer_p0;
  logic [4:0]      addr_p0;
  logic [XLEN-1:0] data_p0;

  logic            we_p1;
  logic [4:0]      addr_p1;
  logic [XLEN-1:0] data_p1;
  logic            gid_p1;

  // Stage p0: grant decision, combinational from state and valids.
  always_comb begin
    wb_ready  = 1'b0;
    dbg_ready = 1'b0;
    if (rst) begin
      case (state)
        NORMAL: begin
          if (wb_valid) wb_ready  = 1'b1;
          else          dbg_ready = dbg_valid;
        end
        FORCE: begin
          if (dbg_valid) dbg_ready = 1'b1;
          else           wb_ready  = wb_valid;
        end
        HALT:    dbg_ready = dbg_valid;
        default: ;
      endcase
    end
  end

  assign wb_xfer_p0  = wb_valid  & wb_ready;
  assign dbg_xfer_p0 = dbg_valid & dbg_ready;
  assign addr_p0     = dbg_xfer_p0 ? dbg_addr : wb_addr;
  assign data_p0     = dbg_xfer_p0 ? dbg_data : wb_data;

  // Starvation count: only a pending-and-denied debug request counts;
  // a grant or a withdrawn request restarts the count.
  always_comb begin
    cnt_nxt = 3'd0;
    if (dbg_valid && !dbg_ready) begin
      if (cnt >= LIMIT) cnt_nxt = LIMIT;
      else              cnt_nxt = cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORMAL;
      cnt   <= 3'd0;
    end else begin
      cnt <= cnt_nxt;
      if (dbg_halt) begin
        // Halt wins over a simultaneously due FORCE entry.
        state <= HALT;
      end else begin
        case (state)
          NORMAL:  if (cnt_nxt == LIMIT) state <= FORCE;
          FORCE:   if (dbg_xfer_p0 || !dbg_valid) state <= NORMAL;
          HALT: begin
            state <= NORMAL;
            cnt   <= 3'd0;
          end
          default: state <= NORMAL;
        endcase
      end
    end
  end

  // Stage p1: registered write port. Address 0 is a hardwired-zero
  // register, so the handshake completes but the write enable stays low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_p1   <= 1'b0;
      addr_p1 <= 5'd0;
      data_p1 <= '0;
      gid_p1  <= 1'b0;
    end else if (wb_xfer_p0 || dbg_xfer_p0) begin
      we_p1   <= (addr_p0 != 5'd0);
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
      gid_p1  <= dbg_xfer_p0;
    end else begin
      we_p1   <= 1'b0;
    end
  end

  assign WE3      = we_p1;
  assign A3       = addr_p1;
  assign WD3      = data_p1;
  assign grant_id = gid_p1;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of the write port.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive denied debug cycles before a forced debug grant (range 1..7).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wb_valid  input  1  core writeback request (requester 0).
REQ-006 wb_addr  input  5  writeback destination register.
REQ-007 wb_data  input  XLEN  writeback data.
REQ-008 wb_ready  output  1  writeback accepted this cycle.
REQ-009 dbg_valid  input  1  debug/load-unit write request (requester 1).
REQ-010 dbg_addr  input  5  debug destination register.
REQ-011 dbg_data  input  XLEN  debug data.
REQ-012 dbg_ready  output  1  debug accepted this cycle.
REQ-013 dbg_halt  input  1  debug owns the port; core writeback blocked.
REQ-014 WE3  output  1  register-file write enable (registered).
REQ-015 A3  output  5  register-file write address (registered).
REQ-016 WD3  output  XLEN  register-file write data (registered).
REQ-017 grant_id  output  1  requester behind current WE3/A3/WD3 (0=wb, 1=dbg).

Function
REQ-018 Transfer occurs on a requester when valid and ready are both high at a posedge; at most one transfer per cycle.
REQ-019 wb_ready and dbg_ready are combinational from current state and valids; never both high in one cycle.
REQ-020 Latency: an accepted transfer appears on A3/WD3/grant_id, with WE3=1, exactly one cycle later, held one cycle only.
REQ-021 Accepted transfer with address 0 completes the handshake but produces WE3=0 next cycle; A3/WD3/grant_id still update.
REQ-022 No transfer in a cycle -> next cycle WE3=0; A3, WD3, grant_id hold previous values.
REQ-023 FSM states: NORMAL, FORCE, HALT; reset state NORMAL.
REQ-024 NORMAL: wb_valid -> grant wb; else dbg_valid -> grant dbg; else no grant.
REQ-025 FORCE: dbg_valid -> grant dbg, wb_ready=0; else wb rule as NORMAL.
REQ-026 HALT: wb_ready=0 always; dbg_valid -> grant dbg.
REQ-027 Starve counter (3 bits): increments when dbg_valid=1 and dbg_ready=0, saturating at STARVE_LIMIT; clears on dbg transfer or dbg_valid=0.
REQ-028 NORMAL -> FORCE when next counter value equals STARVE_LIMIT; FORCE -> NORMAL after a dbg transfer or when dbg_valid=0.
REQ-029 Any state -> HALT when dbg_halt=1 (takes effect the next cycle; current-cycle grant per current state); HALT -> NORMAL when dbg_halt=0, counter cleared.
REQ-030 dbg_halt has priority over FORCE transition when both are due.
REQ-031 Both requesters targeting the same address in one cycle: only the granted one is written; loser retries, no merging.
REQ-032 Requester dropping valid before acceptance: no write is issued for it; no error state.

Reset
REQ-033 rst low asynchronously forces WE3=0, A3=0, WD3=0, grant_id=0, counter=0, state NORMAL.
REQ-034 While rst low, wb_ready=0 and dbg_ready=0.
REQ-035 A transfer accepted the cycle before rst assertion is dropped (WE3 never asserts for it).
REQ-036 First grant possible in the first posedge with rst high.

Verification
REQ-037 wb_valid=1 addr=5 data=0xDEADBEEF, dbg idle -> wb_ready=1; next cycle WE3=1, A3=5, WD3=0xDEADBEEF, grant_id=0.
REQ-038 Both valid continuously, STARVE_LIMIT=4 -> wb granted 4 cycles, dbg granted 5th cycle, then wb resumes; repeating pattern 4:1.
REQ-039 wb_valid=1 addr=0 data=0x1 -> wb_ready=1; next cycle WE3=0, A3=0, grant_id=0.
REQ-040 dbg_halt=1 with both valid -> from next cycle wb_ready=0 every cycle, dbg granted each cycle; dbg_halt=0 -> wb granted next cycle.
REQ-041 Transfer accepted, rst pulsed low mid-cycle before next posedge -> WE3=0 immediately, all outputs 0, readies 0 during reset.
REQ-042 Random valid/addr/data on both ports 10k cycles -> scoreboard: every accepted nonzero-address transfer yields exactly one WE3 pulse one cycle later with matching A3/WD3/grant_id; never both readies high.
